// File: rtl/regfile_scoreboard.sv
// 32 x 64-bit integer register file with write-first bypass on both read ports,
// plus per-register saturating pending-write counters used by decode for RAW/issue control.
module regfile_scoreboard #(
  parameter int unsigned NREG   = 32,
  parameter int unsigned PEND_W = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [$clog2(NREG)-1:0]  rs1,
  input  logic [$clog2(NREG)-1:0]  rs2,
  output logic [63:0]              rdata1,
  output logic [63:0]              rdata2,
  output logic                     rs1_busy,
  output logic                     rs2_busy,
  input  logic                     issue_valid,
  input  logic                     issue_wen,
  input  logic [$clog2(NREG)-1:0]  issue_rd,
  output logic                     issue_ready,
  input  logic                     wb_valid,
  input  logic                     wb_wen,
  input  logic [$clog2(NREG)-1:0]  wb_rd,
  input  logic [63:0]              wb_wd,
  input  logic                     flush,
  output logic                     pending_any
);

  localparam int unsigned AW = $clog2(NREG);
  localparam logic [PEND_W-1:0] CNT_MAX = '1;

  logic [63:0]       regs    [NREG];
  logic [PEND_W-1:0] cnt     [NREG];
  logic [PEND_W-1:0] cntNext [NREG];

  logic retire;
  logic issueAccept;

  assign retire      = wb_valid & wb_wen & (wb_rd != '0);
  assign issue_ready = !(issue_wen && (issue_rd != '0) && (cnt[issue_rd] == CNT_MAX));
  assign issueAccept = issue_valid & issue_ready & issue_wen & (issue_rd != '0);

  always_comb begin
    rdata1 = '0;
    if (rs1 != '0) rdata1 = (retire && (wb_rd == rs1)) ? wb_wd : regs[rs1];
  end

  always_comb begin
    rdata2 = '0;
    if (rs2 != '0) rdata2 = (retire && (wb_rd == rs2)) ? wb_wd : regs[rs2];
  end

  // A register whose last outstanding write retires this cycle is already free to read.
  assign rs1_busy = (rs1 != '0) && (cnt[rs1] != '0) &&
                    !(retire && (wb_rd == rs1) && (cnt[rs1] == PEND_W'(1)));
  assign rs2_busy = (rs2 != '0) && (cnt[rs2] != '0) &&
                    !(retire && (wb_rd == rs2) && (cnt[rs2] == PEND_W'(1)));

  always_comb begin
    pending_any = 1'b0;
    for (int unsigned i = 0; i < NREG; i++) begin
      pending_any = pending_any | (cnt[i] != '0);
    end
  end

  // Issue and retire to the same register cancel; retiring an idle register leaves it at 0.
  always_comb begin
    for (int unsigned i = 0; i < NREG; i++) begin
      cntNext[i] = cnt[i];
      if (flush) begin
        cntNext[i] = '0;
      end else begin
        if (issueAccept && (issue_rd == AW'(i)) && !(retire && (wb_rd == AW'(i)))) begin
          cntNext[i] = cnt[i] + PEND_W'(1);
        end else if (retire && (wb_rd == AW'(i)) &&
                     !(issueAccept && (issue_rd == AW'(i))) && (cnt[i] != '0)) begin
          cntNext[i] = cnt[i] - PEND_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs[i] <= '0;
        cnt[i]  <= '0;
      end
    end else begin
      if (retire) regs[wb_rd] <= wb_wd;
      for (int unsigned i = 0; i < NREG; i++) begin
        cnt[i] <= cntNext[i];
      end
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: directed vector table, a reset-mid-stream sequence,
// then random traffic checked against an array-based reference model.
module tb_regfile_scoreboard;

  localparam int MAXCNT = 3;

  logic        clk;
  logic        reset;
  logic [4:0]  rs1, rs2;
  logic [63:0] rdata1, rdata2;
  logic        rs1_busy, rs2_busy;
  logic        issue_valid, issue_wen;
  logic [4:0]  issue_rd;
  logic        issue_ready;
  logic        wb_valid, wb_wen;
  logic [4:0]  wb_rd;
  logic [63:0] wb_wd;
  logic        flush;
  logic        pending_any;

  int checks = 0;
  int errors = 0;

  regfile_scoreboard #(.NREG(32), .PEND_W(2)) dut (
    .clk(clk), .reset(reset), .rs1(rs1), .rs2(rs2),
    .rdata1(rdata1), .rdata2(rdata2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .issue_valid(issue_valid), .issue_wen(issue_wen), .issue_rd(issue_rd),
    .issue_ready(issue_ready), .wb_valid(wb_valid), .wb_wen(wb_wen), .wb_rd(wb_rd),
    .wb_wd(wb_wd), .flush(flush), .pending_any(pending_any)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        rst;
    logic [4:0]  r1, r2;
    logic        iv, iw;
    logic [4:0]  ird;
    logic        wv, ww;
    logic [4:0]  wrd;
    logic [63:0] wd;
    logic        fl;
    logic [63:0] e1, e2;
    logic        eb1, eb2, erdy, epa;
  } vec_t;

  // Reference state: architectural values and outstanding-write counts per register.
  logic [63:0] mRegs [32];
  int          mCnt  [32];

  function automatic vec_t mk(logic rst, logic [4:0] r1, logic [4:0] r2,
                              logic iv, logic iw, logic [4:0] ird,
                              logic wv, logic ww, logic [4:0] wrd, logic [63:0] wd,
                              logic fl, logic [63:0] e1, logic [63:0] e2,
                              logic eb1, logic eb2, logic erdy, logic epa);
    vec_t v;
    v.rst = rst; v.r1 = r1; v.r2 = r2; v.iv = iv; v.iw = iw; v.ird = ird;
    v.wv = wv; v.ww = ww; v.wrd = wrd; v.wd = wd; v.fl = fl;
    v.e1 = e1; v.e2 = e2; v.eb1 = eb1; v.eb2 = eb2; v.erdy = erdy; v.epa = epa;
    return v;
  endfunction

  task automatic chk(string nm, int idx, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step=%0d actual=%h required=%h", nm, idx, act, exp);
    end
  endtask

  function automatic logic [63:0] modelRead(vec_t v, logic [4:0] rs);
    if (rs == 0) return 64'd0;
    if (v.wv && v.ww && v.wrd == rs) return v.wd;
    return mRegs[rs];
  endfunction

  function automatic logic modelBusy(vec_t v, logic [4:0] rs);
    logic lastRetiring;
    lastRetiring = v.wv && v.ww && v.wrd == rs && mCnt[rs] == 1;
    return rs != 0 && mCnt[rs] > 0 && !lastRetiring;
  endfunction

  function automatic vec_t withModel(vec_t v);
    vec_t r = v;
    int total = 0;
    r.e1   = modelRead(v, v.r1);
    r.e2   = modelRead(v, v.r2);
    r.eb1  = modelBusy(v, v.r1);
    r.eb2  = modelBusy(v, v.r2);
    r.erdy = !(v.iw && v.ird != 0 && mCnt[v.ird] == MAXCNT);
    for (int i = 0; i < 32; i++) total += mCnt[i];
    r.epa  = total > 0;
    return r;
  endfunction

  task automatic modelStep(vec_t v);
    logic ret, acc;
    if (v.rst) begin
      for (int i = 0; i < 32; i++) begin mRegs[i] = '0; mCnt[i] = 0; end
      return;
    end
    ret = v.wv && v.ww && v.wrd != 0;
    acc = v.iv && v.iw && v.ird != 0 && mCnt[v.ird] < MAXCNT;
    if (ret) mRegs[v.wrd] = v.wd;
    if (v.fl) begin
      for (int i = 0; i < 32; i++) mCnt[i] = 0;
    end else if (!(acc && ret && v.ird == v.wrd)) begin
      if (acc) mCnt[v.ird] = mCnt[v.ird] + 1;
      if (ret && mCnt[v.wrd] > 0) mCnt[v.wrd] = mCnt[v.wrd] - 1;
    end
  endtask

  // useModel=1 takes expectations from the reference model instead of the vector.
  task automatic doCycle(vec_t v, bit doCheck, bit useModel, int idx);
    vec_t e;
    @(negedge clk);
    reset = v.rst; rs1 = v.r1; rs2 = v.r2;
    issue_valid = v.iv; issue_wen = v.iw; issue_rd = v.ird;
    wb_valid = v.wv; wb_wen = v.ww; wb_rd = v.wrd; wb_wd = v.wd; flush = v.fl;
    #1;
    e = useModel ? withModel(v) : v;
    if (doCheck) begin
      chk("rdata1", idx, rdata1, e.e1);
      chk("rdata2", idx, rdata2, e.e2);
      chk("rs1_busy", idx, 64'(rs1_busy), 64'(e.eb1));
      chk("rs2_busy", idx, 64'(rs2_busy), 64'(e.eb2));
      chk("issue_ready", idx, 64'(issue_ready), 64'(e.erdy));
      chk("pending_any", idx, 64'(pending_any), 64'(e.epa));
    end
    @(posedge clk);
    modelStep(v);
  endtask

  vec_t tbl[$];

  initial begin
    for (int i = 0; i < 32; i++) begin mRegs[i] = '0; mCnt[i] = 0; end

    //        rst r1  r2  iv iw ird wv ww wrd wd          fl e1          e2       b1 b2 rdy pa
    tbl.push_back(mk(0, 5,  0,  0, 0, 0,  0, 0, 0,  64'h0,      0, 64'h0,      64'h0,    0, 0, 1, 0));
    tbl.push_back(mk(0, 0,  0,  0, 0, 0,  1, 1, 0,  64'hDEAD,   0, 64'h0,      64'h0,    0, 0, 1, 0));
    tbl.push_back(mk(0, 0,  3,  1, 1, 3,  0, 0, 0,  64'h0,      0, 64'h0,      64'h0,    0, 0, 1, 0));
    tbl.push_back(mk(0, 3,  0,  0, 0, 0,  1, 1, 3,  64'h1234,   0, 64'h1234,   64'h0,    0, 0, 1, 1));
    tbl.push_back(mk(0, 3,  3,  1, 1, 7,  0, 0, 0,  64'h0,      0, 64'h1234,   64'h1234, 0, 0, 1, 0));
    tbl.push_back(mk(0, 7,  0,  1, 1, 7,  0, 0, 0,  64'h0,      0, 64'h0,      64'h0,    1, 0, 1, 1));
    tbl.push_back(mk(0, 7,  0,  1, 1, 7,  0, 0, 0,  64'h0,      0, 64'h0,      64'h0,    1, 0, 1, 1));
    tbl.push_back(mk(0, 7,  0,  1, 1, 7,  0, 0, 0,  64'h0,      0, 64'h0,      64'h0,    1, 0, 0, 1));
    tbl.push_back(mk(0, 7,  0,  0, 1, 7,  1, 1, 7,  64'h77,     0, 64'h77,     64'h0,    1, 0, 0, 1));
    tbl.push_back(mk(0, 7,  0,  0, 1, 7,  0, 0, 0,  64'h0,      0, 64'h77,     64'h0,    1, 0, 1, 1));
    tbl.push_back(mk(0, 7,  0,  0, 0, 0,  1, 1, 7,  64'h78,     0, 64'h78,     64'h0,    1, 0, 1, 1));
    tbl.push_back(mk(0, 7,  0,  0, 0, 0,  1, 1, 7,  64'h79,     0, 64'h79,     64'h0,    0, 0, 1, 1));
    tbl.push_back(mk(0, 7,  0,  1, 1, 9,  0, 0, 0,  64'h0,      0, 64'h79,     64'h0,    0, 0, 1, 0));
    tbl.push_back(mk(0, 9,  0,  1, 1, 9,  1, 1, 9,  64'h99,     0, 64'h99,     64'h0,    0, 0, 1, 1));
    tbl.push_back(mk(0, 9,  0,  1, 1, 4,  0, 0, 0,  64'h0,      0, 64'h99,     64'h0,    1, 0, 1, 1));
    tbl.push_back(mk(0, 4,  5,  1, 1, 5,  0, 0, 0,  64'h0,      0, 64'h0,      64'h0,    1, 0, 1, 1));
    tbl.push_back(mk(0, 4,  6,  1, 1, 6,  1, 1, 4,  64'hAA,     1, 64'hAA,     64'h0,    0, 0, 1, 1));
    tbl.push_back(mk(0, 4,  9,  0, 0, 0,  0, 0, 0,  64'h0,      0, 64'hAA,     64'h99,   0, 0, 1, 0));
    tbl.push_back(mk(0, 12, 0,  0, 0, 0,  1, 1, 12, 64'hC,      0, 64'hC,      64'h0,    0, 0, 1, 0));
    tbl.push_back(mk(0, 12, 0,  1, 1, 12, 0, 0, 0,  64'h0,      0, 64'hC,      64'h0,    0, 0, 1, 0));
    tbl.push_back(mk(0, 12, 6,  0, 0, 0,  0, 0, 0,  64'h0,      0, 64'hC,      64'h0,    1, 0, 1, 1));

    doCycle(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 64'h0, 0, 0, 0, 0, 0, 0, 0), 0, 0, -1);
    doCycle(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 64'h0, 0, 0, 0, 0, 0, 0, 0), 0, 0, -1);

    foreach (tbl[i]) doCycle(tbl[i], 1, 0, i);

    // Reset mid-stream: pending writes plus a concurrent writeback that must not land.
    doCycle(mk(0, 2,  0, 1, 1, 2, 0, 0, 0,  64'h0,    0, 64'h0, 64'h0, 0, 0, 1, 1), 1, 0, 100);
    doCycle(mk(1, 0,  0, 1, 1, 2, 1, 1, 12, 64'hFFFF, 0, 0, 0, 0, 0, 0, 0),       0, 0, 101);
    doCycle(mk(0, 12, 2, 0, 0, 0, 0, 0, 0,  64'h0,    0, 64'h0, 64'h0, 0, 0, 1, 0), 1, 0, 102);
    doCycle(mk(0, 4,  9, 0, 1, 2, 0, 0, 0,  64'h0,    0, 64'h0, 64'h0, 0, 0, 1, 0), 1, 0, 103);

    // Random traffic on a narrow register window so hazards and saturation are frequent.
    for (int n = 0; n < 1500; n++) begin
      vec_t v;
      v = mk($urandom_range(63) == 0, 5'($urandom_range(7)), 5'($urandom_range(7)),
             $urandom_range(1), $urandom_range(3) != 0, 5'($urandom_range(7)),
             $urandom_range(2) == 0, $urandom_range(3) != 0, 5'($urandom_range(7)),
             {$urandom, $urandom}, $urandom_range(15) == 0,
             64'h0, 64'h0, 0, 0, 0, 0);
      doCycle(v, 1, 1, 1000 + n);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
